// File: rtl/fabric_rx_dispatcher.sv
// fabric_rx_dispatcher: per-port sequencer between the ingress RX FIFO and the
// crossbar. For each head-of-line frame it runs a MAC lookup, builds a
// destination mask (unicast / flood / self-drop), arbitrates for the crossbar,
// streams the frame beats out and pops the frame from the FIFO.
module fabric_rx_dispatcher #(
  parameter int NUM_PORTS      = 16,
  parameter int PORT_NUM       = 0,
  parameter int LOOKUP_TIMEOUT = 15
) (
  input  logic                         fabric_clk,
  input  logic                         fabric_rst,
  input  logic                         rx_frame_valid,
  input  logic [47:0]                  rx_frame_dst_mac,
  input  logic [47:0]                  rx_frame_src_mac,
  input  logic [11:0]                  rx_frame_vlan,
  input  logic [10:0]                  rx_frame_len,
  output logic                         rx_fwd_en,
  input  logic                         rx_fwd_valid,
  input  logic [3:0]                   rx_fwd_bytes_valid,
  input  logic [63:0]                  rx_fwd_data,
  output logic                         rx_pop,
  output logic                         lookup_en,
  output logic [47:0]                  lookup_src_mac,
  output logic [47:0]                  lookup_dst_mac,
  output logic [11:0]                  lookup_vlan,
  input  logic                         lookup_done,
  input  logic                         lookup_hit,
  input  logic [$clog2(NUM_PORTS)-1:0] lookup_port,
  output logic                         xbar_req,
  output logic [NUM_PORTS-1:0]         xbar_dst_mask,
  input  logic                         xbar_grant,
  output logic                         out_valid,
  output logic                         out_last,
  output logic [3:0]                   out_bytes_valid,
  output logic [63:0]                  out_data,
  output logic [11:0]                  out_vlan,
  output logic                         perf_forwarded,
  output logic                         perf_flooded,
  output logic                         perf_drop_self,
  output logic                         perf_lookup_timeout
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int TMR_W  = $clog2(LOOKUP_TIMEOUT + 1);
  localparam logic [NUM_PORTS-1:0] FLOOD_MASK = ~(NUM_PORTS'(1) << PORT_NUM);
  localparam logic [PORT_W-1:0]    SELF_PORT  = PORT_W'(PORT_NUM);
  localparam logic [TMR_W-1:0]     TMR_LAST   = TMR_W'(LOOKUP_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, ARB, STREAM, HOLDOFF} state_t;

  state_t                 state_q, state_d;
  logic [47:0]            dst_mac_q, dst_mac_d;
  logic [47:0]            src_mac_q, src_mac_d;
  logic [11:0]            vlan_q, vlan_d;
  logic [10:0]            len_q, len_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [NUM_PORTS-1:0]   mask_q, mask_d;
  logic [8:0]             beat_cnt_q, beat_cnt_d;
  logic                   hold_cnt_q, hold_cnt_d;
  logic                   lookup_en_q, lookup_en_d;
  logic                   rx_fwd_en_q, rx_fwd_en_d;
  logic                   rx_pop_q, rx_pop_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [3:0]             out_bytes_q, out_bytes_d;
  logic [63:0]            out_data_q, out_data_d;
  logic                   perf_fwd_q, perf_fwd_d;
  logic                   perf_flood_q, perf_flood_d;
  logic                   perf_drop_q, perf_drop_d;
  logic                   perf_tmo_q, perf_tmo_d;
  logic [8:0]             words;

  // Frame length in 64-bit words, rounded up: whole words plus one for any tail bytes.
  assign words = {1'b0, len_q[10:3]} + {8'd0, |len_q[2:0]};

  // Next-state and registered-output computation; every pulse defaults low.
  always_comb begin
    state_d      = state_q;
    dst_mac_d    = dst_mac_q;
    src_mac_d    = src_mac_q;
    vlan_d       = vlan_q;
    len_d        = len_q;
    timer_d      = timer_q;
    mask_d       = mask_q;
    beat_cnt_d   = beat_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    lookup_en_d  = 1'b0;
    rx_fwd_en_d  = 1'b0;
    rx_pop_d     = 1'b0;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    out_bytes_d  = '0;
    out_data_d   = '0;
    perf_fwd_d   = 1'b0;
    perf_flood_d = 1'b0;
    perf_drop_d  = 1'b0;
    perf_tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_frame_valid) begin
          dst_mac_d   = rx_frame_dst_mac;
          src_mac_d   = rx_frame_src_mac;
          vlan_d      = rx_frame_vlan;
          len_d       = rx_frame_len;
          timer_d     = '0;
          lookup_en_d = 1'b1;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        timer_d = timer_q + 1'b1;
        if (lookup_done) begin
          if (dst_mac_q[40] || !lookup_hit) begin
            mask_d       = FLOOD_MASK;
            perf_flood_d = 1'b1;
            state_d      = ARB;
          end else if (lookup_port == SELF_PORT) begin
            rx_pop_d    = 1'b1;
            perf_drop_d = 1'b1;
            hold_cnt_d  = 1'b0;
            state_d     = HOLDOFF;
          end else begin
            mask_d  = NUM_PORTS'(1) << lookup_port;
            state_d = ARB;
          end
        end else if (timer_q == TMR_LAST) begin
          mask_d       = FLOOD_MASK;
          perf_flood_d = 1'b1;
          perf_tmo_d   = 1'b1;
          state_d      = ARB;
        end
      end
      ARB: begin
        if (xbar_grant) begin
          rx_fwd_en_d = 1'b1;
          beat_cnt_d  = '0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (out_last_q) begin
          hold_cnt_d = 1'b0;
          state_d    = HOLDOFF;
        end else if (rx_fwd_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = rx_fwd_data;
          out_bytes_d = rx_fwd_bytes_valid;
          beat_cnt_d  = beat_cnt_q + 9'd1;
          if (beat_cnt_q == words - 9'd1) begin
            out_last_d = 1'b1;
            rx_pop_d   = 1'b1;
            perf_fwd_d = 1'b1;
          end
        end
      end
      HOLDOFF: begin
        hold_cnt_d = 1'b1;
        if (hold_cnt_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset that abandons any frame.
  always_ff @(posedge fabric_clk) begin
    if (fabric_rst) begin
      state_q      <= IDLE;
      dst_mac_q    <= '0;
      src_mac_q    <= '0;
      vlan_q       <= '0;
      len_q        <= '0;
      timer_q      <= '0;
      mask_q       <= '0;
      beat_cnt_q   <= '0;
      hold_cnt_q   <= 1'b0;
      lookup_en_q  <= 1'b0;
      rx_fwd_en_q  <= 1'b0;
      rx_pop_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_bytes_q  <= '0;
      out_data_q   <= '0;
      perf_fwd_q   <= 1'b0;
      perf_flood_q <= 1'b0;
      perf_drop_q  <= 1'b0;
      perf_tmo_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dst_mac_q    <= dst_mac_d;
      src_mac_q    <= src_mac_d;
      vlan_q       <= vlan_d;
      len_q        <= len_d;
      timer_q      <= timer_d;
      mask_q       <= mask_d;
      beat_cnt_q   <= beat_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      lookup_en_q  <= lookup_en_d;
      rx_fwd_en_q  <= rx_fwd_en_d;
      rx_pop_q     <= rx_pop_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_bytes_q  <= out_bytes_d;
      out_data_q   <= out_data_d;
      perf_fwd_q   <= perf_fwd_d;
      perf_flood_q <= perf_flood_d;
      perf_drop_q  <= perf_drop_d;
      perf_tmo_q   <= perf_tmo_d;
    end
  end

  // The request stays up through the out_last cycle (state is still STREAM then).
  assign xbar_req            = (state_q == ARB) || (state_q == STREAM);
  assign xbar_dst_mask       = xbar_req ? mask_q : '0;
  assign out_vlan            = (state_q == STREAM) ? vlan_q : '0;
  assign lookup_en           = lookup_en_q;
  assign lookup_src_mac      = src_mac_q;
  assign lookup_dst_mac      = dst_mac_q;
  assign lookup_vlan         = vlan_q;
  assign rx_fwd_en           = rx_fwd_en_q;
  assign rx_pop              = rx_pop_q;
  assign out_valid           = out_valid_q;
  assign out_last            = out_last_q;
  assign out_bytes_valid     = out_bytes_q;
  assign out_data            = out_data_q;
  assign perf_forwarded      = perf_fwd_q;
  assign perf_flooded        = perf_flood_q;
  assign perf_drop_self      = perf_drop_q;
  assign perf_lookup_timeout = perf_tmo_q;

endmodule

// File: tb/tb_fabric_rx_dispatcher.sv
// Self-checking bench for fabric_rx_dispatcher: a table of frame scenarios plus
// hand-written back-to-back and mid-stream reset sequences.
module tb_fabric_rx_dispatcher;
  localparam int NUM_PORTS      = 16;
  localparam int PORT_NUM       = 5;
  localparam int LOOKUP_TIMEOUT = 15;

  logic        fabric_clk = 1'b0;
  logic        fabric_rst;
  logic        rx_frame_valid;
  logic [47:0] rx_frame_dst_mac, rx_frame_src_mac;
  logic [11:0] rx_frame_vlan;
  logic [10:0] rx_frame_len;
  logic        rx_fwd_en, rx_fwd_valid, rx_pop;
  logic [3:0]  rx_fwd_bytes_valid;
  logic [63:0] rx_fwd_data;
  logic        lookup_en, lookup_done, lookup_hit;
  logic [47:0] lookup_src_mac, lookup_dst_mac;
  logic [11:0] lookup_vlan;
  logic [3:0]  lookup_port;
  logic        xbar_req, xbar_grant;
  logic [15:0] xbar_dst_mask;
  logic        out_valid, out_last;
  logic [3:0]  out_bytes_valid;
  logic [63:0] out_data;
  logic [11:0] out_vlan;
  logic        perf_forwarded, perf_flooded, perf_drop_self, perf_lookup_timeout;

  fabric_rx_dispatcher #(
    .NUM_PORTS(NUM_PORTS), .PORT_NUM(PORT_NUM), .LOOKUP_TIMEOUT(LOOKUP_TIMEOUT)
  ) dut (
    .fabric_clk(fabric_clk), .fabric_rst(fabric_rst),
    .rx_frame_valid(rx_frame_valid), .rx_frame_dst_mac(rx_frame_dst_mac),
    .rx_frame_src_mac(rx_frame_src_mac), .rx_frame_vlan(rx_frame_vlan),
    .rx_frame_len(rx_frame_len), .rx_fwd_en(rx_fwd_en), .rx_fwd_valid(rx_fwd_valid),
    .rx_fwd_bytes_valid(rx_fwd_bytes_valid), .rx_fwd_data(rx_fwd_data), .rx_pop(rx_pop),
    .lookup_en(lookup_en), .lookup_src_mac(lookup_src_mac), .lookup_dst_mac(lookup_dst_mac),
    .lookup_vlan(lookup_vlan), .lookup_done(lookup_done), .lookup_hit(lookup_hit),
    .lookup_port(lookup_port), .xbar_req(xbar_req), .xbar_dst_mask(xbar_dst_mask),
    .xbar_grant(xbar_grant), .out_valid(out_valid), .out_last(out_last),
    .out_bytes_valid(out_bytes_valid), .out_data(out_data), .out_vlan(out_vlan),
    .perf_forwarded(perf_forwarded), .perf_flooded(perf_flooded),
    .perf_drop_self(perf_drop_self), .perf_lookup_timeout(perf_lookup_timeout)
  );

  always #5 fabric_clk = ~fabric_clk;

  typedef struct {
    logic [47:0] dst;
    logic        hit;
    logic [3:0]  port;
    logic [10:0] len;
    logic        tmo;
    logic [15:0] exp_mask;
    int          exp_beats;
    logic [3:0]  exp_last_bytes;
    logic        exp_flood;
    logic        exp_drop;
  } vec_t;

  vec_t vecs[8];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int frame_id = 0;
  logic [11:0] exp_vlan = '0;

  // Cycle counter used to measure latencies between events.
  always @(posedge fabric_clk) cyc <= cyc + 1;

  function automatic logic [63:0] expData(input int tag, input int b);
    logic [31:0] hi;
    hi = 32'hA5A50000 + 32'(tag);
    return {hi, 32'(b)};
  endfunction

  function automatic string nm(input int id, input string s);
    return $sformatf("f%0d_%s", id, s);
  endfunction

  function automatic logic anyOut();
    return rx_fwd_en | rx_pop | lookup_en | (|lookup_src_mac) | (|lookup_dst_mac) |
           (|lookup_vlan) | xbar_req | (|xbar_dst_mask) | out_valid | out_last |
           (|out_bytes_valid) | (|out_data) | (|out_vlan) | perf_forwarded |
           perf_flooded | perf_drop_self | perf_lookup_timeout;
  endfunction

  // Output monitor: counts events per frame, checks beat payloads on the fly.
  int mon_id = -1;
  int beats_seen, last_count, last_idx, pop_count, pop_on_last, fwd_count;
  int flood_count, drop_count, tmo_count, fwd_en_count, data_err, req_hold_err;
  logic [3:0]  last_bytes;
  logic        req_seen, mask_changed, prev_last;
  logic [15:0] mask_seen;
  always @(negedge fabric_clk) begin
    if (frame_id != mon_id) begin
      mon_id = frame_id;
      beats_seen = 0; last_count = 0; last_idx = -1; pop_count = 0; pop_on_last = 0;
      fwd_count = 0; flood_count = 0; drop_count = 0; tmo_count = 0; fwd_en_count = 0;
      data_err = 0; req_hold_err = 0; last_bytes = '0; req_seen = 1'b0;
      mask_changed = 1'b0; prev_last = 1'b0; mask_seen = '0;
    end
    if (out_valid) begin
      if (out_data !== expData(frame_id, beats_seen) || out_vlan !== exp_vlan) data_err++;
      if (out_last) begin
        last_count++;
        last_idx = beats_seen;
        last_bytes = out_bytes_valid;
      end else if (out_bytes_valid !== 4'd8) data_err++;
      beats_seen++;
    end else if (out_last) data_err++;
    if (rx_pop) begin
      pop_count++;
      if (out_last) pop_on_last++;
    end
    if (perf_forwarded) fwd_count++;
    if (perf_flooded) flood_count++;
    if (perf_drop_self) drop_count++;
    if (perf_lookup_timeout) tmo_count++;
    if (rx_fwd_en) fwd_en_count++;
    if (prev_last && xbar_req) req_hold_err++;
    prev_last = out_last;
    if (xbar_req) begin
      if (!req_seen) mask_seen = xbar_dst_mask;
      else if (xbar_dst_mask !== mask_seen) mask_changed = 1'b1;
      req_seen = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present a frame at the FIFO head (caller is just past a posedge) and wait for lookup_en.
  task automatic startFrame(input int id, input logic [47:0] dst, input logic [10:0] len,
                            output int lcyc);
    int  scyc;
    logic found;
    frame_id = id;
    exp_vlan = 12'h100 + 12'(id);
    rx_frame_valid = 1'b1;
    rx_frame_dst_mac = dst;
    rx_frame_src_mac = 48'h0A00_0000_0000 + 48'(id);
    rx_frame_vlan = exp_vlan;
    rx_frame_len = len;
    scyc = cyc;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge fabric_clk);
      if (lookup_en) begin found = 1'b1; break; end
    end
    lcyc = cyc;
    checkOutput(nm(id, "lookup_en_lat"), found ? 64'(lcyc - scyc) : 64'hFFFF, 64'd1);
    checkOutput(nm(id, "lookup_dst"), lookup_dst_mac, dst);
    checkOutput(nm(id, "lookup_src"), lookup_src_mac, 48'h0A00_0000_0000 + 48'(id));
    checkOutput(nm(id, "lookup_vlan"), lookup_vlan, exp_vlan);
  endtask

  // One-cycle lookup response; returns at the negedge of the following cycle.
  task automatic doLookup(input logic hit, input logic [3:0] port);
    @(posedge fabric_clk); #1;
    lookup_done = 1'b1; lookup_hit = hit; lookup_port = port;
    @(posedge fabric_clk); #1;
    lookup_done = 1'b0; lookup_hit = 1'b0; lookup_port = '0;
    @(negedge fabric_clk);
  endtask

  // Grant two cycles after the request, then feed the frame beats (optional one-cycle gap).
  task automatic grantStream(input int id, input int beats, input logic [3:0] lb, input logic gap);
    @(posedge fabric_clk); @(posedge fabric_clk); #1;
    xbar_grant = 1'b1;
    @(posedge fabric_clk); #1;
    xbar_grant = 1'b0;
    @(negedge fabric_clk);
    checkOutput(nm(id, "fwd_en"), rx_fwd_en, 1'b1);
    for (int b = 0; b < beats; b++) begin
      if (gap && b == 2) begin
        @(posedge fabric_clk); #1;
        rx_fwd_valid = 1'b0; rx_fwd_data = '0; rx_fwd_bytes_valid = '0;
      end
      @(posedge fabric_clk); #1;
      rx_fwd_valid = 1'b1;
      rx_fwd_data = expData(id, b);
      rx_fwd_bytes_valid = (b == beats - 1) ? lb : 4'd8;
    end
    @(posedge fabric_clk); #1;
    rx_fwd_valid = 1'b0; rx_fwd_data = '0; rx_fwd_bytes_valid = '0;
  endtask

  // Run one table scenario end to end and compare the per-frame event counts.
  task automatic applyStimulus(input int id, input vec_t v);
    int   lcyc, tcyc;
    logic found;
    @(posedge fabric_clk); #1;
    startFrame(id, v.dst, v.len, lcyc);
    @(posedge fabric_clk); #1;
    rx_frame_valid = 1'b0;
    if (v.tmo) begin
      found = 1'b0; tcyc = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge fabric_clk);
        if (perf_lookup_timeout) begin found = 1'b1; tcyc = cyc; break; end
      end
      checkOutput(nm(id, "tmo_lat"), found ? 64'(tcyc - lcyc) : 64'hFFFF, 64'(LOOKUP_TIMEOUT));
      checkOutput(nm(id, "tmo_req"), xbar_req, 1'b1);
      doLookup(1'b1, 4'd3);
      checkOutput(nm(id, "late_done_mask"), xbar_dst_mask, v.exp_mask);
    end else begin
      doLookup(v.hit, v.port);
      checkOutput(nm(id, "req_after_done"), xbar_req, !v.exp_drop);
      if (v.exp_drop) checkOutput(nm(id, "drop_pop_timing"), rx_pop, 1'b1);
    end
    if (v.exp_drop) begin
      @(posedge fabric_clk); #1;
      rx_fwd_valid = 1'b1; xbar_grant = 1'b1;
      @(posedge fabric_clk); #1;
      @(posedge fabric_clk); #1;
      rx_fwd_valid = 1'b0; xbar_grant = 1'b0;
    end else begin
      grantStream(id, v.exp_beats, v.exp_last_bytes, id % 2 == 1);
    end
    repeat (6) @(posedge fabric_clk);
    #1;
    checkOutput(nm(id, "beats"), beats_seen, v.exp_drop ? 0 : v.exp_beats);
    checkOutput(nm(id, "last_count"), last_count, v.exp_drop ? 0 : 1);
    checkOutput(nm(id, "pop_count"), pop_count, 1);
    checkOutput(nm(id, "pop_on_last"), pop_on_last, v.exp_drop ? 0 : 1);
    checkOutput(nm(id, "forwarded"), fwd_count, v.exp_drop ? 0 : 1);
    checkOutput(nm(id, "drop_self"), drop_count, v.exp_drop ? 1 : 0);
    checkOutput(nm(id, "fwd_en_count"), fwd_en_count, v.exp_drop ? 0 : 1);
    checkOutput(nm(id, "timeouts"), tmo_count, v.tmo ? 1 : 0);
    checkOutput(nm(id, "data_err"), data_err, 0);
    checkOutput(nm(id, "req_hold_err"), req_hold_err, 0);
    if (!v.tmo) checkOutput(nm(id, "flooded"), flood_count, v.exp_flood ? 1 : 0);
    if (v.exp_drop) begin
      checkOutput(nm(id, "no_req"), req_seen, 1'b0);
    end else begin
      checkOutput(nm(id, "last_idx"), last_idx, v.exp_beats - 1);
      checkOutput(nm(id, "last_bytes"), last_bytes, v.exp_last_bytes);
      checkOutput(nm(id, "mask"), mask_seen, v.exp_mask);
      checkOutput(nm(id, "mask_stable"), mask_changed, 1'b0);
    end
  endtask

  initial begin
    int   lcyc, pcyc;
    logic found;
    vecs[0] = '{48'h0200_0000_0011, 1'b1, 4'd3,  11'd60,   1'b0, 16'h0008, 8,   4'd4, 1'b0, 1'b0};
    vecs[1] = '{48'hFFFF_FFFF_FFFF, 1'b1, 4'd3,  11'd100,  1'b0, 16'hFFDF, 13,  4'd4, 1'b1, 1'b0};
    vecs[2] = '{48'h0200_0000_0022, 1'b1, 4'd5,  11'd60,   1'b0, 16'h0000, 0,   4'd0, 1'b0, 1'b1};
    vecs[3] = '{48'h0200_0000_0033, 1'b0, 4'd0,  11'd64,   1'b0, 16'hFFDF, 8,   4'd8, 1'b1, 1'b0};
    vecs[4] = '{48'h0200_0000_0044, 1'b0, 4'd0,  11'd64,   1'b1, 16'hFFDF, 8,   4'd8, 1'b1, 1'b0};
    vecs[5] = '{48'h0200_0000_0055, 1'b1, 4'd15, 11'd1500, 1'b0, 16'h8000, 188, 4'd4, 1'b0, 1'b0};
    vecs[6] = '{48'h0100_5E00_0001, 1'b1, 4'd2,  11'd65,   1'b0, 16'hFFDF, 9,   4'd1, 1'b1, 1'b0};
    vecs[7] = '{48'h0200_0000_0077, 1'b1, 4'd0,  11'd61,   1'b0, 16'h0001, 8,   4'd5, 1'b0, 1'b0};

    fabric_rst = 1'b1;
    rx_frame_valid = 1'b0; rx_frame_dst_mac = '0; rx_frame_src_mac = '0;
    rx_frame_vlan = '0; rx_frame_len = '0;
    rx_fwd_valid = 1'b0; rx_fwd_bytes_valid = '0; rx_fwd_data = '0;
    lookup_done = 1'b0; lookup_hit = 1'b0; lookup_port = '0; xbar_grant = 1'b0;
    repeat (3) @(posedge fabric_clk);
    @(negedge fabric_clk);
    checkOutput("reset_outputs", anyOut(), 1'b0);
    @(posedge fabric_clk); #1;
    fabric_rst = 1'b0;
    @(negedge fabric_clk);
    checkOutput("post_reset_idle", anyOut(), 1'b0);

    for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

    // Back-to-back frames: the FIFO keeps rx_frame_valid high across the pop.
    @(posedge fabric_clk); #1;
    startFrame(10, 48'h0200_0000_00AA, 11'd64, lcyc);
    doLookup(1'b1, 4'd3);
    checkOutput("b2b_req", xbar_req, 1'b1);
    grantStream(10, 8, 4'd8, 1'b0);
    rx_frame_dst_mac = 48'h0200_0000_00BB;
    rx_frame_src_mac = 48'h0A00_0000_000B;
    rx_frame_vlan = 12'h10B;
    rx_frame_len = 11'd200;
    @(negedge fabric_clk);
    pcyc = cyc;
    checkOutput("b2b_pop_with_last", {rx_pop, out_last}, 2'b11);
    @(negedge fabric_clk);
    checkOutput("b2b_hold1_req", xbar_req, 1'b0);
    @(negedge fabric_clk);
    checkOutput("b2b_hold2_req", xbar_req, 1'b0);
    checkOutput("b2b_first_beats", beats_seen, 8);
    checkOutput("b2b_first_last_idx", last_idx, 7);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge fabric_clk);
      if (lookup_en) begin found = 1'b1; break; end
    end
    checkOutput("b2b_gap", found ? 64'(cyc - pcyc) : 64'hFFFF, 64'd4);
    checkOutput("b2b_next_dst", lookup_dst_mac, 48'h0200_0000_00BB);

    // Second frame is abandoned by a reset after three streamed beats.
    @(posedge fabric_clk); #1;
    rx_frame_valid = 1'b0;
    frame_id = 11;
    exp_vlan = 12'h10B;
    doLookup(1'b1, 4'd3);
    checkOutput("rst_req", xbar_req, 1'b1);
    @(posedge fabric_clk); #1;
    xbar_grant = 1'b1;
    @(posedge fabric_clk); #1;
    xbar_grant = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(posedge fabric_clk); #1;
      rx_fwd_valid = 1'b1; rx_fwd_data = expData(11, b); rx_fwd_bytes_valid = 4'd8;
    end
    @(posedge fabric_clk); #1;
    fabric_rst = 1'b1;
    rx_fwd_valid = 1'b0; rx_fwd_data = '0; rx_fwd_bytes_valid = '0;
    @(posedge fabric_clk); #1;
    fabric_rst = 1'b0;
    @(negedge fabric_clk);
    checkOutput("rst_outputs_zero", anyOut(), 1'b0);
    repeat (3) @(negedge fabric_clk);
    checkOutput("rst_no_pop", pop_count, 0);
    checkOutput("rst_beats_before", beats_seen, 3);

    applyStimulus(20, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net in case some wait never completes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
